alarm_trigger_fsm: RTL and testbench



---
 rtl/alarm_trigger_fsm.sv | 155 +++++++++++++++
 tb/tb_alarm_trigger_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_trigger_fsm.sv
// alarm_trigger_fsm: decides when the alarm rings by watching for the moment the
// running clock time (hh:mm, BCD) becomes equal to the alarm time. It manages
// the ring timeout, the stop button and, optionally, snooze. It drives the
// buzzer enable and a 0.5 Hz blinking LED.
// Optional feature macro: ALARM_SNOOZE_EN (snooze state and snooze_active output).
module alarm_trigger_fsm #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarm_enable,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  input  logic [1:0] alm_hours_tenth,
  input  logic [3:0] alm_hours_units,
  input  logic [2:0] alm_minutes_tenth,
  input  logic [3:0] alm_minutes_units,
  input  logic [1:0] cur_hours_tenth,
  input  logic [3:0] cur_hours_units,
  input  logic [2:0] cur_minutes_tenth,
  input  logic [3:0] cur_minutes_units,
  output logic       buzzer,
  output logic       alarm_led,
  output logic       snooze_active,
  output logic       ringing
);

  localparam int MAX_S = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int CNT_W = $clog2(MAX_S) + 1;
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_S - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_S - 1);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             match;
  logic             match_q;
  logic             trigger;

`ifndef ALARM_SNOOZE_EN
  // Snooze input has no function when the snooze feature is left out.
  logic unused_snooze;
  assign unused_snooze = snooze_btn;
`endif

  assign match = ({alm_hours_tenth, alm_hours_units, alm_minutes_tenth, alm_minutes_units} ==
                  {cur_hours_tenth, cur_hours_units, cur_minutes_tenth, cur_minutes_units});

  // Only the rising edge of the match fires the alarm, so a held match never retriggers.
  assign trigger = match & ~match_q & alarm_enable;

  // Previous match value; resets to 1 so a match already present at reset release is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) match_q <= 1'b1;
    else      match_q <= match;
  end

  // Ring/snooze state machine with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      buzzer        <= 1'b0;
      alarm_led     <= 1'b0;
      snooze_active <= 1'b0;
      ringing       <= 1'b0;
    end else if (!alarm_enable) begin
      state         <= IDLE;
      cnt           <= '0;
      buzzer        <= 1'b0;
      alarm_led     <= 1'b0;
      snooze_active <= 1'b0;
      ringing       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= RINGING;
            cnt       <= '0;
            buzzer    <= 1'b1;
            alarm_led <= 1'b1;
            ringing   <= 1'b1;
          end
        end
        RINGING: begin
          if (stop_btn) begin
            state     <= IDLE;
            cnt       <= '0;
            buzzer    <= 1'b0;
            alarm_led <= 1'b0;
            ringing   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze_btn) begin
            state         <= SNOOZE;
            cnt           <= '0;
            buzzer        <= 1'b0;
            alarm_led     <= 1'b0;
            ringing       <= 1'b0;
            snooze_active <= 1'b1;
`endif
          end else if (tick_1hz) begin
            if (cnt == RING_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              buzzer    <= 1'b0;
              alarm_led <= 1'b0;
              ringing   <= 1'b0;
            end else begin
              cnt       <= cnt + 1'b1;
              alarm_led <= ~alarm_led;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop_btn) begin
            state         <= IDLE;
            cnt           <= '0;
            snooze_active <= 1'b0;
          end else if (tick_1hz) begin
            if (cnt == SNOOZE_LAST) begin
              state         <= RINGING;
              cnt           <= '0;
              buzzer        <= 1'b1;
              alarm_led     <= 1'b1;
              ringing       <= 1'b1;
              snooze_active <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`endif
        default: begin
          state         <= IDLE;
          cnt           <= '0;
          buzzer        <= 1'b0;
          alarm_led     <= 1'b0;
          snooze_active <= 1'b0;
          ringing       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_trigger_fsm.sv
// Directed testbench for alarm_trigger_fsm with RING_TIMEOUT_S=5, SNOOZE_S=3.
module tb_alarm_trigger_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       alarm_enable;
  logic       stop_btn;
  logic       snooze_btn;
  logic [1:0] alm_hours_tenth;
  logic [3:0] alm_hours_units;
  logic [2:0] alm_minutes_tenth;
  logic [3:0] alm_minutes_units;
  logic [1:0] cur_hours_tenth;
  logic [3:0] cur_hours_units;
  logic [2:0] cur_minutes_tenth;
  logic [3:0] cur_minutes_units;
  logic       buzzer;
  logic       alarm_led;
  logic       snooze_active;
  logic       ringing;

  int n_cmp = 0;
  int n_err = 0;

  alarm_trigger_fsm #(
    .RING_TIMEOUT_S(5),
    .SNOOZE_S      (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tick_1hz         (tick_1hz),
    .alarm_enable     (alarm_enable),
    .stop_btn         (stop_btn),
    .snooze_btn       (snooze_btn),
    .alm_hours_tenth  (alm_hours_tenth),
    .alm_hours_units  (alm_hours_units),
    .alm_minutes_tenth(alm_minutes_tenth),
    .alm_minutes_units(alm_minutes_units),
    .cur_hours_tenth  (cur_hours_tenth),
    .cur_hours_units  (cur_hours_units),
    .cur_minutes_tenth(cur_minutes_tenth),
    .cur_minutes_units(cur_minutes_units),
    .buzzer           (buzzer),
    .alarm_led        (alarm_led),
    .snooze_active    (snooze_active),
    .ringing          (ringing)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic observed, input logic expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic chk_out(input string tag, input logic b, input logic l, input logic s, input logic r);
    chk({tag, ".buzzer"}, buzzer, b);
    chk({tag, ".led"}, alarm_led, l);
    chk({tag, ".snooze"}, snooze_active, s);
    chk({tag, ".ringing"}, ringing, r);
  endtask

  task automatic set_alm(input logic [1:0] ht, input logic [3:0] hu, input logic [2:0] mt, input logic [3:0] mu);
    alm_hours_tenth = ht; alm_hours_units = hu; alm_minutes_tenth = mt; alm_minutes_units = mu;
  endtask

  task automatic set_cur(input logic [1:0] ht, input logic [3:0] hu, input logic [2:0] mt, input logic [3:0] mu);
    cur_hours_tenth = ht; cur_hours_units = hu; cur_minutes_tenth = mt; cur_minutes_units = mu;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  // Clock steps 07:29 -> 07:30 with the alarm at 07:30; rings after the second edge.
  task automatic ring_0730();
    set_cur(2'd0, 4'd7, 3'd2, 4'd9);
    step();
    set_cur(2'd0, 4'd7, 3'd3, 4'd0);
    step();
  endtask

  initial begin
    rst = 1'b0; tick_1hz = 1'b0; alarm_enable = 1'b1; stop_btn = 1'b0; snooze_btn = 1'b0;
    set_alm(2'd0, 4'd7, 3'd3, 4'd0);
    set_cur(2'd0, 4'd7, 3'd2, 4'd9);
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(); step();
    chk_out("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // 1: ring, LED pattern 1,0,1,0,1, timeout on the 5th tick
    set_cur(2'd0, 4'd7, 3'd3, 4'd0);
    step();
    chk_out("t1.enter", 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("t1.no_tick_hold", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("t1.tick1", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); chk_out("t1.tick2", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("t1.tick3", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); chk_out("t1.tick4", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("t1.tick5_timeout", 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: stop together with a tick, then no retrigger while the match is held
    ring_0730();
    chk_out("t2.enter", 1'b1, 1'b1, 1'b0, 1'b1);
    stop_btn = 1'b1; tick_1hz = 1'b1;
    step();
    stop_btn = 1'b0; tick_1hz = 1'b0;
    chk_out("t2.stop", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk_out("t2.no_retrigger", 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: snooze (counter cleared on snooze entry and on return to ringing)
    ring_0730();
    tick();
    chk_out("t3.pre_snooze", 1'b1, 1'b0, 1'b0, 1'b1);
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
`ifdef ALARM_SNOOZE_EN
    chk_out("t3.snooze", 1'b0, 1'b0, 1'b1, 1'b0);
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    chk_out("t3.snooze_ignored", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    chk_out("t3.snooze_2ticks", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("t3.rering", 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); tick(); tick(); tick();
    chk_out("t3.rering_4ticks", 1'b1, 1'b1, 1'b0, 1'b1);
`else
    chk_out("t3.snooze_no_effect", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("t3.still_ringing", 1'b1, 1'b1, 1'b0, 1'b1);
`endif
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
    chk_out("t3.stop", 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: stop and snooze together -> stop wins
    ring_0730();
    chk_out("t4.enter", 1'b1, 1'b1, 1'b0, 1'b1);
    stop_btn = 1'b1; snooze_btn = 1'b1;
    step();
    stop_btn = 1'b0; snooze_btn = 1'b0;
    chk_out("t4.stop_wins", 1'b0, 1'b0, 1'b0, 1'b0);

    // 5: match held through reset release, midnight rollover, enable drop
    rst = 1'b0;
    set_alm(2'd0, 4'd0, 3'd0, 4'd0);
    set_cur(2'd0, 4'd0, 3'd0, 4'd0);
    step();
    rst = 1'b1;
    step(); step(); step();
    chk_out("t5.no_ring_at_release", 1'b0, 1'b0, 1'b0, 1'b0);
    set_cur(2'd2, 4'd3, 3'd5, 4'd9);
    step();
    set_cur(2'd0, 4'd0, 3'd0, 4'd0);
    step();
    chk_out("t5.midnight_ring", 1'b1, 1'b1, 1'b0, 1'b1);
    alarm_enable = 1'b0;
    step();
    chk_out("t5.disable", 1'b0, 1'b0, 1'b0, 1'b0);
    alarm_enable = 1'b1;
    step(); step();
    chk_out("t5.reenable_no_ring", 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: asynchronous reset mid-ring, no ring after release with match held
    set_cur(2'd2, 4'd3, 3'd5, 4'd9);
    step();
    set_cur(2'd0, 4'd0, 3'd0, 4'd0);
    step();
    chk_out("t6.enter", 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_out("t6.async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    step(); step(); step();
    chk_out("t6.no_ring_after_release", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
